// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/step controller for the single-cycle CPU. It drives the CPU's initPC
// line, decides each cycle whether the instruction currently presented by
// the CPU commits, counts committed instructions, and stops the CPU on a
// commit limit, a PC breakpoint, a halt opcode or an external request.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   initPC       synchronous active-high reset of this controller
//   start        IDLE: begin a run; HALTED: resume
//   restart      any state: re-initialise the CPU and clear the count
//   step         HALTED: execute exactly one instruction
//   halt_req     external halt request (honoured in RUN only)
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC
//   regPC        CPU current PC
//   inst         CPU current instruction
//   cpu_init     drives the CPU's initPC
//   cpu_en       CPU commit enable for this cycle (combinational)
//   cycle_count  committed instructions since the last init (saturating)
//   running      state is RUN or STEP
//   halted       state is HALTED
//   halt_reason  0 none, 1 max cycles, 2 breakpoint, 3 halt inst,
//                4 external, 5 step done
module cpu_run_ctrl #(
    parameter int unsigned MAX_CYCLES  = 0,
    parameter int unsigned INIT_CYCLES = 1,
    parameter logic [31:0] HALT_INST   = 32'hFFFF_FFFF,
    parameter int          CW          = 32
) (
    input  logic          clk,
    input  logic          initPC,
    input  logic          start,
    input  logic          restart,
    input  logic          step,
    input  logic          halt_req,
    input  logic          bp_en,
    input  logic [31:0]   bp_addr,
    input  logic [31:0]   regPC,
    input  logic [31:0]   inst,
    output logic          cpu_init,
    output logic          cpu_en,
    output logic [CW-1:0] cycle_count,
    output logic          running,
    output logic          halted,
    output logic [2:0]    halt_reason
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_STEP,
        S_HALTED
    } state_t;

    localparam logic [2:0] R_NONE = 3'd0;
    localparam logic [2:0] R_MAX  = 3'd1;
    localparam logic [2:0] R_BP   = 3'd2;
    localparam logic [2:0] R_HALT = 3'd3;
    localparam logic [2:0] R_EXT  = 3'd4;
    localparam logic [2:0] R_STEP = 3'd5;

    // Init counter runs 0 .. INIT_CYCLES-1; at least one bit wide.
    localparam int          IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [IW-1:0] INIT_ONE  = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] MAX_CW    = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    state_t          state_reg;
    logic [IW-1:0]   init_cnt_reg;
    logic [CW-1:0]   cycle_count_reg;
    logic [2:0]      halt_reason_reg;
    // Set on resume from HALTED so the instruction sitting on the
    // breakpoint commits once instead of re-triggering immediately.
    logic            bp_skip_reg;

    logic [2:0]      run_reason;
    logic            halt_cond;
    logic            is_halt_inst;
    logic            reason_locked;
    logic [CW-1:0]   count_next;

    assign is_halt_inst = (inst == HALT_INST);

    // Halt check for the instruction about to commit in RUN, highest
    // priority first.
    always_comb begin
        run_reason = R_NONE;
        if (halt_req) begin
            run_reason = R_EXT;
        end else if (is_halt_inst) begin
            run_reason = R_HALT;
        end else if (bp_en && (regPC == bp_addr) && !bp_skip_reg) begin
            run_reason = R_BP;
        end else if ((MAX_CYCLES != 0) && (cycle_count_reg == MAX_CW)) begin
            run_reason = R_MAX;
        end
    end

    assign halt_cond = (run_reason != R_NONE);

    // Commit limit and halt opcode are terminal: only restart/initPC leave.
    assign reason_locked = (halt_reason_reg == R_MAX) || (halt_reason_reg == R_HALT);

    // Saturating increment.
    assign count_next = (cycle_count_reg == {CW{1'b1}}) ? cycle_count_reg
                                                         : cycle_count_reg + CNT_ONE;

    // A restart in RUN/STEP pre-empts this cycle's commit because the
    // count is being cleared in the same cycle.
    always_comb begin
        cpu_en = 1'b0;
        case (state_reg)
            S_INIT:  cpu_en = 1'b1;
            S_RUN:   cpu_en = !halt_cond && !restart;
            S_STEP:  cpu_en = !is_halt_inst && !restart;
            default: cpu_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (initPC) begin
            state_reg       <= S_IDLE;
            init_cnt_reg    <= '0;
            cycle_count_reg <= '0;
            halt_reason_reg <= R_NONE;
            bp_skip_reg     <= 1'b0;
        end else if (restart) begin
            state_reg       <= S_INIT;
            init_cnt_reg    <= '0;
            cycle_count_reg <= '0;
            halt_reason_reg <= R_NONE;
            bp_skip_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_INIT;
                        init_cnt_reg <= '0;
                    end
                end
                S_INIT: begin
                    if (init_cnt_reg == INIT_LAST) begin
                        state_reg <= S_RUN;
                    end else begin
                        init_cnt_reg <= init_cnt_reg + INIT_ONE;
                    end
                end
                S_RUN: begin
                    if (halt_cond) begin
                        state_reg       <= S_HALTED;
                        halt_reason_reg <= run_reason;
                    end else begin
                        cycle_count_reg <= count_next;
                        bp_skip_reg     <= 1'b0;
                    end
                end
                S_STEP: begin
                    state_reg <= S_HALTED;
                    if (is_halt_inst) begin
                        halt_reason_reg <= R_HALT;
                    end else begin
                        cycle_count_reg <= count_next;
                        halt_reason_reg <= R_STEP;
                    end
                end
                S_HALTED: begin
                    if (!reason_locked) begin
                        if (start) begin
                            state_reg   <= S_RUN;
                            bp_skip_reg <= 1'b1;
                        end else if (step) begin
                            state_reg <= S_STEP;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign cpu_init    = (state_reg == S_INIT);
    assign running     = (state_reg == S_RUN) || (state_reg == S_STEP);
    assign halted      = (state_reg == S_HALTED);
    assign cycle_count = cycle_count_reg;
    assign halt_reason = halt_reason_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl. Two instances share the stimulus: instance A
// (MAX_CYCLES=10, INIT_CYCLES=1, 32-bit count) and instance B (unlimited,
// INIT_CYCLES=3, 3-bit count so saturation is reachable). A behavioural
// model per instance is checked every cycle on the falling edge; directed
// scenarios add literal expectations. The bench also plays the CPU: the PC
// resets on cpu_init and advances by 4 (wrapping at pc_wrap) on each commit.
module tb_cpu_run_ctrl;

    localparam logic [31:0] HALT    = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam int unsigned MAX_A   = 10;
    localparam int unsigned INIT_A  = 1;
    localparam int unsigned INIT_B  = 3;
    localparam int          CW_B    = 3;

    logic        clk = 1'b0;
    logic        initPC = 1'b1;
    logic        start = 1'b0, restart = 1'b0, step = 1'b0, halt_req = 1'b0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0, inst = NOP;
    logic [31:0] pc = 32'h0;
    logic [31:0] pc_wrap = 32'h14;

    logic            cpu_init_a, cpu_en_a, running_a, halted_a;
    logic [31:0]     cycle_count_a;
    logic [2:0]      halt_reason_a;
    logic            cpu_init_b, cpu_en_b, running_b, halted_b;
    logic [CW_B-1:0] cycle_count_b;
    logic [2:0]      halt_reason_b;

    int passed = 0;
    int total  = 0;
    bit chk_on = 1'b0;
    bit exp_init_a = 1'b0;
    bit exp_en_a   = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(.MAX_CYCLES(MAX_A), .INIT_CYCLES(INIT_A), .HALT_INST(HALT), .CW(32)) u_a (
        .clk(clk), .initPC(initPC), .start(start), .restart(restart), .step(step),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .regPC(pc), .inst(inst),
        .cpu_init(cpu_init_a), .cpu_en(cpu_en_a), .cycle_count(cycle_count_a),
        .running(running_a), .halted(halted_a), .halt_reason(halt_reason_a)
    );

    cpu_run_ctrl #(.MAX_CYCLES(0), .INIT_CYCLES(INIT_B), .HALT_INST(HALT), .CW(CW_B)) u_b (
        .clk(clk), .initPC(initPC), .start(start), .restart(restart), .step(step),
        .halt_req(halt_req), .bp_en(bp_en), .bp_addr(bp_addr), .regPC(pc), .inst(inst),
        .cpu_init(cpu_init_b), .cpu_en(cpu_en_b), .cycle_count(cycle_count_b),
        .running(running_b), .halted(halted_b), .halt_reason(halt_reason_b)
    );

    // ---------------- behavioural model ----------------
    // Nothing set means idle; init_left>0 means CPU held in init.
    typedef struct {
        int     init_left;
        bit     run;
        bit     stp;
        bit     stop;
        longint count;
        int     reason;
        bit     skip;
    } mdl_t;

    mdl_t m_a, m_b;

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.init_left = 0; z.run = 0; z.stp = 0; z.stop = 0;
        z.count = 0; z.reason = 0; z.skip = 0;
        return z;
    endfunction

    function automatic int why(mdl_t m, int unsigned maxc);
        if (halt_req) return 4;
        if (inst == HALT) return 3;
        if (bp_en && pc == bp_addr && !m.skip) return 2;
        if (maxc != 0 && m.count == longint'(maxc)) return 1;
        return 0;
    endfunction

    function automatic bit en_of(mdl_t m, int unsigned maxc);
        if (m.init_left > 0) return 1'b1;
        if (m.run) return !restart && why(m, maxc) == 0;
        if (m.stp) return !restart && inst != HALT;
        return 1'b0;
    endfunction

    function automatic longint bump(longint c, int cw);
        longint top = (longint'(1) << cw) - 1;
        return (c >= top) ? top : c + 1;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int unsigned icyc, int unsigned maxc, int cw);
        mdl_t n;
        int   w;
        n = m;
        if (initPC) begin
            n = mdl_zero();
        end else if (restart) begin
            n = mdl_zero();
            n.init_left = int'(icyc);
        end else if (m.init_left > 0) begin
            n.init_left = m.init_left - 1;
            if (n.init_left == 0) n.run = 1;
        end else if (m.run) begin
            w = why(m, maxc);
            if (w != 0) begin
                n.run = 0; n.stop = 1; n.reason = w;
            end else begin
                n.count = bump(m.count, cw); n.skip = 0;
            end
        end else if (m.stp) begin
            n.stp = 0; n.stop = 1;
            if (inst == HALT) n.reason = 3;
            else begin n.count = bump(m.count, cw); n.reason = 5; end
        end else if (m.stop) begin
            if (m.reason != 1 && m.reason != 3) begin
                if (start) begin n.stop = 0; n.run = 1; n.skip = 1; end
                else if (step) begin n.stop = 0; n.stp = 1; end
            end
        end else if (start) begin
            n.init_left = int'(icyc);
        end
        return n;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    initial begin
        m_a = mdl_zero();
        m_b = mdl_zero();
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        exp_init_a = (m_a.init_left > 0);
        exp_en_a   = en_of(m_a, MAX_A);
        if (chk_on) begin
            chk("a.cpu_init",    cpu_init_a,    exp_init_a);
            chk("a.cpu_en",      cpu_en_a,      exp_en_a);
            chk("a.cycle_count", cycle_count_a, m_a.count);
            chk("a.running",     running_a,     m_a.run || m_a.stp);
            chk("a.halted",      halted_a,      m_a.stop);
            chk("a.halt_reason", halt_reason_a, m_a.reason);
            chk("b.cpu_init",    cpu_init_b,    m_b.init_left > 0);
            chk("b.cpu_en",      cpu_en_b,      en_of(m_b, 0));
            chk("b.cycle_count", cycle_count_b, m_b.count);
            chk("b.running",     running_b,     m_b.run || m_b.stp);
            chk("b.halted",      halted_b,      m_b.stop);
            chk("b.halt_reason", halt_reason_b, m_b.reason);
        end
    end

    // Model advance plus the bench's stand-in CPU (driven by model A).
    always @(posedge clk) begin
        m_a = mdl_next(m_a, INIT_A, MAX_A, 32);
        m_b = mdl_next(m_b, INIT_B, 0, CW_B);
        if (exp_init_a) pc <= 32'h0;
        else if (exp_en_a) pc <= (pc + 32'd4 >= pc_wrap) ? 32'h0 : pc + 32'd4;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and first run
        cyc();
        chk_on = 1'b1;
        chk("rst.cpu_init", cpu_init_a, 0);
        chk("rst.running", running_a, 0);
        chk("rst.halted", halted_a, 0);
        chk("rst.count", cycle_count_a, 0);
        initPC = 1'b0; start = 1'b1;
        cyc();
        chk("init.cpu_init", cpu_init_a, 1);
        chk("init.cpu_en", cpu_en_a, 1);
        start = 1'b0;
        cyc();
        chk("run.cpu_init", cpu_init_a, 0);
        chk("run.running", running_a, 1);
        chk("run.cpu_en", cpu_en_a, 1);
        repeat (5) cyc();
        chk("run.count5", cycle_count_a, 5);
        chk("model.count5", m_a.count, 5);

        // Commit limit
        repeat (5) cyc();
        chk("max.count", cycle_count_a, 10);
        chk("max.cpu_en", cpu_en_a, 0);
        cyc();
        chk("max.halted", halted_a, 1);
        chk("max.reason", halt_reason_a, 1);
        start = 1'b1; cyc(); start = 1'b0;
        chk("max.start_ignored", halted_a, 1);
        step = 1'b1; cyc(); step = 1'b0;
        chk("max.step_ignored", halted_a, 1);
        chk("max.count_held", cycle_count_a, 10);
        restart = 1'b1; bp_en = 1'b1; bp_addr = 32'h10;
        cyc();
        chk("restart.cpu_init", cpu_init_a, 1);
        chk("restart.count", cycle_count_a, 0);
        chk("restart.reason", halt_reason_a, 0);

        // Breakpoint at 0x10
        restart = 1'b0;
        cyc();
        chk("bp.pc0", pc, 0);
        repeat (4) cyc();
        chk("bp.pc", pc, 32'h10);
        #1 chk("bp.cpu_en", cpu_en_a, 0);
        cyc();
        chk("bp.halted", halted_a, 1);
        chk("bp.reason", halt_reason_a, 2);
        chk("bp.count", cycle_count_a, 4);
        start = 1'b1; cyc(); start = 1'b0;
        #1 chk("bp.resume_en", cpu_en_a, 1);
        cyc();
        chk("bp.resume_count", cycle_count_a, 5);
        repeat (5) cyc();
        chk("bp.again_halted", halted_a, 1);
        chk("bp.again_reason", halt_reason_a, 2);
        chk("bp.again_count", cycle_count_a, 9);
        for (int i = 1; i <= 3; i++) begin
            step = 1'b1; cyc(); step = 1'b0;
            #1 chk("step.cpu_en", cpu_en_a, 1);
            cyc();
            chk("step.reason", halt_reason_a, 5);
            chk("step.count", cycle_count_a, 9 + i);
            chk("model.step_count", m_a.count, 9 + i);
        end

        // Halt opcode at count 7
        bp_en = 1'b0; restart = 1'b1; cyc(); restart = 1'b0; cyc();
        repeat (7) cyc();
        inst = HALT;
        #1 chk("hinst.cpu_en", cpu_en_a, 0);
        cyc();
        chk("hinst.reason", halt_reason_a, 3);
        chk("hinst.count", cycle_count_a, 7);
        start = 1'b1; cyc(); start = 1'b0;
        step = 1'b1; cyc(); step = 1'b0;
        chk("hinst.still_halted", halted_a, 1);
        chk("hinst.reason_held", halt_reason_a, 3);
        inst = NOP;

        // halt_req together with a breakpoint, then initPC mid-run
        bp_en = 1'b1; bp_addr = 32'h8;
        restart = 1'b1; cyc(); restart = 1'b0; cyc();
        repeat (2) cyc();
        halt_req = 1'b1;
        #1 chk("ext.cpu_en", cpu_en_a, 0);
        cyc();
        chk("ext.reason", halt_reason_a, 4);
        repeat (2) cyc();
        chk("ext.held_reason", halt_reason_a, 4);
        halt_req = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        repeat (2) cyc();
        chk("ext.resume_count", cycle_count_a, 4);
        initPC = 1'b1; cyc(); initPC = 1'b0;
        chk("init_mid.running", running_a, 0);
        chk("init_mid.count", cycle_count_a, 0);
        chk("init_mid.cpu_en", cpu_en_a, 0);

        // Randomised phase, model checked every cycle
        for (int n = 0; n < 4000; n++) begin
            initPC   = ($urandom_range(0, 199) == 0);
            restart  = ($urandom_range(0, 63) == 0);
            start    = ($urandom_range(0, 7) == 0);
            step     = ($urandom_range(0, 5) == 0);
            halt_req = ($urandom_range(0, 19) == 0);
            inst     = ($urandom_range(0, 24) == 0) ? HALT : $urandom();
            if ($urandom_range(0, 31) == 0) begin
                bp_en   = $urandom_range(0, 1);
                bp_addr = 32'($urandom_range(0, 7)) << 2;
            end
            if ($urandom_range(0, 255) == 0) pc_wrap = 32'($urandom_range(3, 16)) << 2;
            cyc();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step controller that sequences the single-cycle CPU. It generates the CPU's initPC pulse and a per-cycle commit enable, and counts committed instructions. It halts the CPU on a cycle limit, a PC breakpoint, a halt opcode or an external request. It sits beside the CPU, replacing hand-toggled clock/initPC sequences in benches and top-levels.

Parameters:
MAX_CYCLES, 0, commit limit; 0 = unlimited
INIT_CYCLES, 1, cycles cpu_init is held high (min 1)
HALT_INST, 32'hFFFF_FFFF, instruction word that halts before commit
CW, 32, cycle_count width

Ports:
clk  in  1  clock, all state changes on rising edge
initPC  in  1  synchronous active-high reset of this controller
start  in  1  IDLE: begin run; HALTED: resume
restart  in  1  any state: re-init CPU, clear count
step  in  1  HALTED: execute exactly one instruction
halt_req  in  1  external halt request
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
regPC  in  32  CPU current PC
inst  in  32  CPU current instruction
cpu_init  out  1  drives CPU initPC
cpu_en  out  1  CPU commit enable for this cycle (combinational)
cycle_count  out  CW  committed instructions since last init
running  out  1  state is RUN or STEP
halted  out  1  state is HALTED
halt_reason  out  3  0 none, 1 max cycles, 2 breakpoint, 3 halt inst, 4 external, 5 step done

Behaviour:
- States: IDLE, INIT, RUN, STEP, HALTED. initPC forces IDLE; cycle_count=0, halt_reason=0, init counter=0, bp_skip=0. Outputs in IDLE: cpu_init=0, cpu_en=0, running=0, halted=0.
- restart has priority over all inputs except initPC. From any state it goes to INIT, clears cycle_count and halt_reason, and clears bp_skip.
- IDLE: start -> INIT. Other inputs are ignored.
- INIT: cpu_init=1 and cpu_en=1 for exactly INIT_CYCLES cycles, then RUN. No counting or halt checks in INIT.
- halt_cond (RUN only), evaluated combinationally on regPC/inst of the instruction about to commit. Priority high->low:
  - halt_req -> reason 4
  - inst==HALT_INST -> reason 3
  - bp_en && regPC==bp_addr && !bp_skip -> reason 2
  - MAX_CYCLES!=0 && cycle_count==MAX_CYCLES -> reason 1
- RUN, no halt_cond: cpu_en=1 and cycle_count++. bp_skip clears after the first committed cycle.
- RUN, halt_cond: cpu_en=0 (instruction not committed), cycle_count unchanged, next state HALTED, halt_reason latched.
- HALTED: cpu_en=0, halted=1.
  - start resumes to RUN and sets bp_skip=1, so the breakpoint instruction commits once.
  - start is ignored when halt_reason is 1 or 3; only restart leaves these.
  - step -> STEP, unless halt_reason is 1 or 3 (step ignored).
  - start and step together: start wins.
- STEP: exactly one cycle, cpu_en=1, cycle_count++, breakpoint/halt_req ignored. Next state HALTED with halt_reason=5.
  - If inst==HALT_INST: cpu_en=0, no count, reason 3.
- cycle_count saturates at all-ones and never wraps.
- halt_req held high in HALTED has no effect. halt_req in IDLE/INIT is ignored.
- halt_reason holds its value until restart, initPC, or a new halt.

Test Plan:
- initPC=1 for 1 cycle, then start, INIT_CYCLES=1 -> cpu_init=1 for exactly 1 cycle, then running=1, cpu_en=1; cycle_count=5 after 5 RUN cycles.
- MAX_CYCLES=10, free run -> cycle_count stops at 10, cpu_en=0 on the 11th RUN cycle, halted=1, halt_reason=1; start ignored; restart -> count 0, cpu_init pulses.
- bp_en=1, bp_addr=32'h0000_0010, PC sequence 0,4,8,C,10 -> halt with count=4, reason 2; start -> PC 10 commits (cpu_en=1, count 5), and a later revisit of 10 halts again.
- Halted at breakpoint, pulse step 3 times -> count +3, cpu_en high one cycle each, halt_reason=5 after each step.
- inst=32'hFFFF_FFFF appears at count 7 -> cpu_en=0, reason 3, count stays 7; step and start ignored.
- halt_req and a breakpoint match in the same cycle -> reason 4. initPC asserted mid-RUN -> next cycle IDLE, all outputs 0, count 0.
